// File: rtl/lc3_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lc3_mem_ctrl
//   LC-3 memory interface stage. It holds the MAR and MDR and runs one
//   handshaked read or write per request. It also pulses R to the control FSM
//   when the access completes. A watchdog ends an access whose memory never
//   answers and sets a sticky error flag.
//
// Parameters
//   TIMEOUT    max cycles spent in REQ waiting for mem_ready (0 = no watchdog)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   Buss       processor data bus
//   ldMAR      load MAR from Buss (IDLE only)
//   ldMDR      load MDR from Buss (IDLE only)
//   memEN      start access (level, sampled in IDLE)
//   memWE      1 = write, 0 = read; sampled with memEN
//   MAROut     current MAR
//   MDROut     current MDR
//   R          access complete, one-cycle pulse
//   busy       access in progress (REQ or DONE)
//   err        sticky timeout flag, cleared only by reset
//   mem_addr   memory address (= MAR)
//   mem_wdata  memory write data (= MDR)
//   mem_req    memory request strobe
//   mem_we     memory write enable, valid with mem_req
//   mem_rdata  memory read data, valid with mem_ready
//   mem_ready  memory done; meaningful only while mem_req = 1
// ---------------------------------------------------------------------------
module lc3_mem_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] Buss,
   input  logic        ldMAR,
   input  logic        ldMDR,
   input  logic        memEN,
   input  logic        memWE,
   output logic [15:0] MAROut,
   output logic [15:0] MDROut,
   output logic        R,
   output logic        busy,
   output logic        err,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_req,
   output logic        mem_we,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready
);

   // The timer must be able to hold TIMEOUT. It is at least 1 bit wide.
   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } stateT;

   stateT         state;
   stateT         nextState;
   logic [15:0]   mar;
   logic [15:0]   mdr;
   logic [TW-1:0] timer;
   logic          weQ;
   logic          errQ;
   logic          timeoutHit;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   // Next state. When mem_ready and the timeout land in the same cycle,
   // mem_ready wins.
   always_comb begin
      nextState  = state;
      timeoutHit = 1'b0;
      case (state)
         IDLE: if (memEN) nextState = REQ;
         REQ: begin
            if (mem_ready) begin
               nextState = DONE;
            end else if ((TIMEOUT != 0) && (timer == TLAST)) begin
               nextState  = DONE;
               timeoutHit = 1'b1;
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Datapath registers. Loads are honoured only in IDLE. A load in the same
   // cycle as memEN therefore reaches the access that starts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mar   <= '0;
         mdr   <= '0;
         timer <= '0;
         weQ   <= 1'b0;
         errQ  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ldMAR) mar <= Buss;
               if (ldMDR) mdr <= Buss;
               if (memEN) begin
                  weQ   <= memWE;
                  timer <= '0;
               end
            end
            REQ: begin
               if (mem_ready) begin
                  if (!weQ) mdr <= mem_rdata;
               end else begin
                  timer <= timer + TW'(1);
                  if (timeoutHit) errQ <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // All handshake outputs are decoded from state. An asynchronous reset
   // therefore drops them at once.
   assign MAROut    = mar;
   assign MDROut    = mdr;
   assign mem_addr  = mar;
   assign mem_wdata = mdr;
   assign mem_req   = (state == REQ);
   assign mem_we    = (state == REQ) && weQ;
   assign R         = (state == DONE);
   assign busy      = (state != IDLE);
   assign err       = errQ;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lc3_mem_ctrl
//   Self-checking bench for lc3_mem_ctrl (TIMEOUT = 4). It runs directed
//   scenarios and then randomized accesses. Results are compared against a
//   transaction-level model of MAR/MDR/err and of the expected request length.
// ---------------------------------------------------------------------------
module tb_lc3_mem_ctrl;
   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] Buss;
   logic        ldMAR, ldMDR, memEN, memWE;
   logic [15:0] MAROut, MDROut;
   logic        R, busy, err;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_req, mem_we;
   logic [15:0] mem_rdata;
   logic        mem_ready;

   lc3_mem_ctrl #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .Buss      (Buss),
      .ldMAR     (ldMAR),
      .ldMDR     (ldMDR),
      .memEN     (memEN),
      .memWE     (memWE),
      .MAROut    (MAROut),
      .MDROut    (MDROut),
      .R         (R),
      .busy      (busy),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   int unsigned nTests = 0;
   int unsigned nFail  = 0;

   // Reference state, at transaction level
   logic [15:0] mMAR;
   logic [15:0] mMDR;
   logic        mErr;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One complete access. The first cycle optionally loads MAR. The second
   // cycle raises memEN and optionally loads MDR. The memory answers in REQ
   // cycle index w (0-based); w >= TO means it never answers. When junk is
   // set, the bench drives loads and memEN during REQ; the DUT must ignore them.
   task automatic doAccess(input logic ldA, input logic [15:0] addr,
                           input logic ldD, input logic [15:0] data,
                           input logic we, input int w,
                           input logic [15:0] rdata, input logic junk);
      int unsigned reqCycles;
      int unsigned expReq;
      logic        timedOut;
      @(negedge clk);
      Buss  = addr;
      ldMAR = ldA;
      @(negedge clk);
      ldMAR = 1'b0;
      Buss  = data;
      ldMDR = ldD;
      memEN = 1'b1;
      memWE = we;
      if (ldA) mMAR = addr;
      if (ldD) mMDR = data;
      timedOut  = (w >= int'(TO));
      expReq    = timedOut ? TO : w + 1;
      reqCycles = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         ldMAR     = 1'b0;
         ldMDR     = 1'b0;
         memEN     = 1'b0;
         mem_ready = 1'b0;
         if (!mem_req) break;
         checkVal("reqAddr", mem_addr, mMAR);
         checkVal("reqWdata", mem_wdata, mMDR);
         checkVal("reqWe", mem_we, we);
         checkVal("reqBusy", busy, 1'b1);
         checkVal("reqR", R, 1'b0);
         mem_ready = (reqCycles == w);
         mem_rdata = rdata;
         if (junk) begin
            Buss  = 16'($urandom);
            ldMAR = 1'b1;
            ldMDR = 1'b1;
            memEN = 1'b1;
         end
         reqCycles++;
      end
      if (!timedOut && !we) mMDR = rdata;
      if (timedOut) mErr = 1'b1;
      checkVal("reqCycles", reqCycles, expReq);
      checkVal("doneR", R, 1'b1);
      checkVal("doneBusy", busy, 1'b1);
      checkVal("doneMDR", MDROut, mMDR);
      checkVal("doneMAR", MAROut, mMAR);
      checkVal("doneErr", err, mErr);
      @(negedge clk);
      checkVal("idleR", R, 1'b0);
      checkVal("idleBusy", busy, 1'b0);
      checkVal("idleReq", mem_req, 1'b0);
   endtask

   initial begin
      reset = 1'b0; Buss = '0; ldMAR = 1'b0; ldMDR = 1'b0; memEN = 1'b0; memWE = 1'b0;
      mem_rdata = '0; mem_ready = 1'b0;
      mMAR = '0; mMDR = '0; mErr = 1'b0;
      repeat (2) @(negedge clk);
      checkVal("rstMAR", MAROut, 16'h0);
      checkVal("rstMDR", MDROut, 16'h0);
      checkVal("rstR", R, 1'b0);
      checkVal("rstBusy", busy, 1'b0);
      checkVal("rstErr", err, 1'b0);
      checkVal("rstReq", mem_req, 1'b0);
      checkVal("rstWe", mem_we, 1'b0);
      reset = 1'b1;

      // Zero-wait read
      doAccess(1'b1, 16'h3000, 1'b0, 16'h0, 1'b0, 0, 16'h1234, 1'b0);
      // Write with 3 wait states (ready coincides with the timeout cycle)
      doAccess(1'b1, 16'h4001, 1'b1, 16'hBEEF, 1'b1, 3, 16'h5555, 1'b0);

      // Same-cycle ldMAR + memEN, then ldMAR during REQ is ignored
      @(negedge clk);
      Buss = 16'h00FF; ldMAR = 1'b1; memEN = 1'b1; memWE = 1'b0;
      mMAR = 16'h00FF;
      @(negedge clk);
      checkVal("sameAddr", mem_addr, 16'h00FF);
      checkVal("sameReq", mem_req, 1'b1);
      Buss = 16'h1111; ldMAR = 1'b1; memEN = 1'b0;
      mem_ready = 1'b1; mem_rdata = 16'h0F0F;
      mMDR = 16'h0F0F;
      @(negedge clk);
      ldMAR = 1'b0; mem_ready = 1'b0;
      checkVal("sameR", R, 1'b1);
      checkVal("sameMAR", MAROut, 16'h00FF);
      checkVal("sameMDR", MDROut, 16'h0F0F);
      @(negedge clk);

      // Timeout, then a normal read with err still set
      doAccess(1'b1, 16'h5000, 1'b0, 16'h0, 1'b0, 9, 16'hDEAD, 1'b0);
      doAccess(1'b1, 16'h5001, 1'b0, 16'h0, 1'b0, 1, 16'hCAFE, 1'b0);

      // Back-to-back reads with memEN held high through DONE
      @(negedge clk);
      memEN = 1'b1; memWE = 1'b0;
      @(negedge clk);
      checkVal("b2bReq1", mem_req, 1'b1);
      mem_ready = 1'b1; mem_rdata = 16'hA001;
      @(negedge clk);
      mem_ready = 1'b0;
      checkVal("b2bR1", R, 1'b1);
      checkVal("b2bMDR1", MDROut, 16'hA001);
      @(negedge clk);
      checkVal("b2bIdle", mem_req, 1'b0);
      checkVal("b2bIdleR", R, 1'b0);
      @(negedge clk);
      checkVal("b2bReq2", mem_req, 1'b1);
      mem_ready = 1'b1; mem_rdata = 16'hA002;
      @(negedge clk);
      mem_ready = 1'b0; memEN = 1'b0;
      checkVal("b2bR2", R, 1'b1);
      checkVal("b2bMDR2", MDROut, 16'hA002);
      mMDR = 16'hA002;
      @(negedge clk);
      @(negedge clk);
      checkVal("b2bStop", mem_req, 1'b0);

      // Randomized accesses
      for (int n = 0; n < 200; n++) begin
         doAccess(1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
                  1'($urandom), int'($urandom_range(0, 5)), 16'($urandom),
                  1'($urandom));
      end

      // Asynchronous reset in the middle of REQ
      @(negedge clk);
      Buss = 16'hA5A5; ldMAR = 1'b1; ldMDR = 1'b1; memEN = 1'b1; memWE = 1'b0;
      @(negedge clk);
      ldMAR = 1'b0; ldMDR = 1'b0; memEN = 1'b0;
      checkVal("arReqBefore", mem_req, 1'b1);
      #2 reset = 1'b0;
      #1;
      checkVal("arReq", mem_req, 1'b0);
      checkVal("arBusy", busy, 1'b0);
      checkVal("arMAR", MAROut, 16'h0);
      checkVal("arMDR", MDROut, 16'h0);
      checkVal("arErr", err, 1'b0);
      mMAR = '0; mMDR = '0; mErr = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkVal("arNoR", R, 1'b0);
         checkVal("arNoReq", mem_req, 1'b0);
      end
      doAccess(1'b1, 16'h7777, 1'b0, 16'h0, 1'b0, 2, 16'h2468, 1'b0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   // Safety net against a hung run
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
